// File: rtl/booth_step19.sv
// Radix-2 Booth sequencer for 9x9 signed multiplies. The 19-bit A:Q:Q-1 register
// lives downstream; this block computes its next value and strobes it.
module booth_step19 (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [8:0]  multiplicand,
  input  logic signed [8:0]  multiplier,
  input  logic        [18:0] q_in,
  output logic        [18:0] d_out,
  output logic               reg_en,
  output logic               reg_load,
  output logic               busy,
  output logic               done,
  output logic signed [17:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic signed [8:0]  m_q, m_d;
  logic signed [8:0]  q_q, q_d;

  // Booth step datapath, driven from the external register contents
  logic signed [8:0]  a_cur;
  logic        [8:0]  q_cur;
  logic               qm1_cur;
  logic signed [9:0]  a_ext;
  logic signed [9:0]  m_ext;
  logic signed [9:0]  sum;
  logic        [18:0] step_val;

  // State register and operand/counter storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      m_q     <= 9'sd0;
      q_q     <= 9'sd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (cnt_q == 4'd8) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured only on acceptance, so later input changes are harmless
  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d = multiplicand;
          q_d = multiplier;
        end
      end
      LOAD:    cnt_d = 4'd0;
      RUN:     cnt_d = cnt_q + 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign a_cur   = q_in[18:10];
  assign q_cur   = q_in[9:1];
  assign qm1_cur = q_in[0];
  assign a_ext   = {a_cur[8], a_cur};
  assign m_ext   = {m_q[8], m_q};

  // Ten-bit sum keeps -(-256) representable; bit 9 becomes the shifted-in sign
  always_comb begin
    case ({q_cur[0], qm1_cur})
      2'b01:   sum = a_ext + m_ext;
      2'b10:   sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase
  end

  assign step_val = {sum[9:1], sum[0], q_cur[8:1], q_cur[0]};

  // Output logic
  always_comb begin
    d_out    = 19'd0;
    reg_en   = 1'b0;
    reg_load = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      LOAD: begin
        d_out    = {9'd0, q_q, 1'b0};
        reg_en   = 1'b1;
        reg_load = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        d_out    = step_val;
        reg_en   = 1'b1;
        reg_load = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign product = q_in[18:1];

endmodule

// File: tb/tb_booth_step19.sv
// Directed and randomized checks of booth_step19 driving a modelled A:Q:Q-1 register.
module tb_booth_step19;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [8:0] multiplicand;
  logic signed [8:0] multiplier;
  logic       [18:0] q_in;
  logic       [18:0] d_out;
  logic              reg_en;
  logic              reg_load;
  logic              busy;
  logic              done;
  logic       [17:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_step19 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .q_in         (q_in),
    .d_out        (d_out),
    .reg_en       (reg_en),
    .reg_load     (reg_load),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Downstream register, reset by the same rst
  always_ff @(posedge clk) begin
    if (rst) q_in <= 19'd0;
    else if (reg_en && reg_load) q_in <= d_out;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One multiply with start in cycle 0; operands scrambled after acceptance and a
  // stray start with garbage operands issued mid-run.
  task automatic do_op(input string tag, input logic signed [8:0] m,
                       input logic signed [8:0] q, input logic [17:0] exp_p);
    int n;
    int loads;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = ~q;
    n     = 1;
    loads = 0;
    while (!done && n < 40) begin
      if (reg_load) loads++;
      start = (n == 4);
      step();
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd11);
    check({tag, " loads"}, 64'(loads), 64'd10);
    check({tag, " product"}, 64'(product), 64'(exp_p));
    $display("[TB] %s: M=%0d Q=%0d product=0x%05h done_cycle=%0d", tag, m, q, product, n);
    step();
    check({tag, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dones;
    logic signed [8:0]  rm, rq;
    logic signed [17:0] rp;

    rst = 1'b1;
    start = 1'b0;
    multiplicand = 9'sd0;
    multiplier = 9'sd0;
    step();
    step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset reg_en", 64'(reg_en), 64'd0);
    check("reset reg_load", 64'(reg_load), 64'd0);
    check("reset d_out", 64'(d_out), 64'd0);
    rst = 1'b0;
    step();

    do_op("m3_qm5", 9'sd3, -9'sd5, 18'h3FFF1);
    do_op("m255_q255", 9'sd255, 9'sd255, 18'h0FE01);
    do_op("mm256_q255", -9'sd256, 9'sd255, 18'h30100);
    do_op("mm256_qm256", -9'sd256, -9'sd256, 18'h10000);
    do_op("m0_qm1", 9'sd0, -9'sd1, 18'h00000);

    // start held high: back-to-back operations, operands wiggled mid-run
    multiplicand = 9'sd7;
    multiplier   = 9'sd9;
    start        = 1'b1;
    step();
    multiplicand = -9'sd100;
    multiplier   = 9'sd50;
    for (int c = 1; c <= 23; c++) begin
      check($sformatf("cont done c%0d", c), 64'(done), 64'((c == 11) || (c == 23)));
      if (c == 11) check("cont product1", 64'(product), 64'h0003F);
      if (c == 23) check("cont product2", 64'(product), 64'h3FFF4);
      if (c == 8) begin
        multiplicand = -9'sd3;
        multiplier   = 9'sd4;
      end
      if (c == 13) begin
        multiplicand = 9'sd100;
        multiplier   = 9'sd100;
      end
      if (c == 23) start = 1'b0;
      step();
    end
    $display("[TB] continuous start: two operations, done at cycles 11 and 23");
    step();

    // Reset in RUN with cnt=4 (cycle 6), start also high to test rst priority
    multiplicand = 9'sd11;
    multiplier   = 9'sd13;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort busy before", 64'(busy), 64'd1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort q_in", 64'(q_in), 64'd0);
    check("abort reg_load", 64'(reg_load), 64'd0);
    check("abort reg_en", 64'(reg_en), 64'd0);
    check("abort d_out", 64'(d_out), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dones++;
      step();
    end
    check("abort no activity", 64'(dones), 64'd0);
    $display("[TB] reset abort at RUN cnt=4: returned to idle");
    do_op("after_abort", -9'sd5, 9'sd7, 18'h3FFDD);

    for (int k = 0; k < 1000; k++) begin
      rm = 9'($urandom_range(0, 511));
      rq = 9'($urandom_range(0, 511));
      rp = rm * rq;
      do_op($sformatf("rand%0d", k), rm, rq, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_step19.md
BOOTH_STEP19 -- requirements
Module: booth_step19

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  in  1  begin a multiply, sampled only in IDLE.
REQ-004 SHALL have: multiplicand  in  9  signed M, captured when start is accepted.
REQ-005 SHALL have: multiplier  in  9  signed Q, captured when start is accepted.
REQ-006 SHALL have: q_in  in  19  current value of the downstream 19-bit A:Q:Q-1 register.
REQ-007 SHALL have: d_out  out  19  next value for that register.
REQ-008 SHALL have: reg_en  out  1  enable to the register.
REQ-009 SHALL have: reg_load  out  1  load strobe to the register; the register updates only when reg_en and reg_load are both 1.
REQ-010 SHALL have: busy  out  1  high in LOAD and RUN.
REQ-011 SHALL have: done  out  1  one-cycle pulse, product valid.
REQ-012 SHALL have: product  out  18  signed result, equal to q_in[18:1].

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE, plus a 4-bit iteration counter cnt.
REQ-014 IDLE: when start=1, SHALL latch multiplicand into internal M_r and multiplier into internal Q_r, then go to LOAD; start=0 stays in IDLE.
REQ-015 LOAD (exactly 1 cycle): SHALL drive reg_en=reg_load=1 and d_out={9'b0, Q_r, 1'b0}, clear cnt, then go to RUN.
REQ-016 RUN (exactly 9 cycles, cnt 0..8): SHALL drive reg_en=reg_load=1 and take A=q_in[18:10], Q=q_in[9:1], Q-1=q_in[0].
REQ-017 RUN, selection on {Q[0], Q-1}: 01 gives S=A+M_r; 10 gives S=A-M_r; 00 and 11 give S=A.
REQ-018 RUN arithmetic: S SHALL be a 10-bit result from sign-extended A and M_r (no 9-bit overflow), and d_out = {S[9:1], S[0], Q[8:1], Q[0]} (arithmetic right shift).
REQ-019 RUN: cnt SHALL increment each cycle; at cnt=8 the next state is DONE.
REQ-020 DONE (exactly 1 cycle): SHALL drive done=1, reg_en=reg_load=0 and product=q_in[18:1], then go to IDLE unconditionally.
REQ-021 Outside LOAD/RUN: reg_en=reg_load=0 and d_out=19'b0; outside DONE: done=0.
REQ-022 Latency: if start is sampled in cycle 0, LOAD SHALL be cycle 1, RUN cycles 2-10, and done=1 in cycle 11; next start is accepted from cycle 12.
REQ-023 start while busy or in DONE SHALL be ignored and SHALL NOT corrupt M_r or Q_r.
REQ-024 Changes to multiplicand or multiplier after acceptance SHALL NOT affect the running operation.
REQ-025 The full signed range SHALL be supported, including -256 x -256 = +65536.

Reset
REQ-026 While rst=1 at a clock edge: state IDLE, cnt=0, M_r=Q_r=0; from the next cycle busy=0, done=0, reg_en=reg_load=0, d_out=0.
REQ-027 rst during LOAD, RUN or DONE SHALL abort the operation with no done pulse; the downstream register is reset by the same rst.
REQ-028 rst has priority over start in the same cycle.

Verification
REQ-029 Shall cover: start, M=3, Q=-5 -> done in cycle 11, product=18'h3FFF1 (-15).
REQ-030 Shall cover: M=255, Q=255 -> product=18'h0FE01 (65025); M=-256, Q=255 -> product=18'h30100.
REQ-031 Shall cover: M=-256, Q=-256 -> product=18'h10000; M=0, Q=-1 -> product=0.
REQ-032 Shall cover: start held high continuously -> one operation per 12 cycles, done pulses exactly 1 cycle each, and operands change mid-run without effect.
REQ-033 Shall cover: rst asserted at RUN cnt=4 -> IDLE next cycle, busy=0, no done, q_in=0; a fresh start then yields a correct product.
REQ-034 Shall cover: random 1000 signed operand pairs -> product equals the reference multiply, and reg_load=1 for exactly 10 cycles per operation.
